// File: rtl/mseq_pkg.sv
// Shared types and constants for the M-sequence generator: FSM state encoding,
// a table of primitive feedback masks and the maximal-period helper.
package mseq_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    RELOAD = 1'b1
  } mseq_state_e;

  // Mask bit i selects state[i] into the feedback XOR; one primitive polynomial per length.
  function automatic logic [31:0] prim_taps(input int w);
    case (w)
      2:       prim_taps = 32'h0000_0003;
      3:       prim_taps = 32'h0000_0006;
      4:       prim_taps = 32'h0000_000C;
      5:       prim_taps = 32'h0000_0014;
      6:       prim_taps = 32'h0000_0030;
      7:       prim_taps = 32'h0000_0060;
      8:       prim_taps = 32'h0000_00B8;
      9:       prim_taps = 32'h0000_0110;
      10:      prim_taps = 32'h0000_0240;
      11:      prim_taps = 32'h0000_0500;
      12:      prim_taps = 32'h0000_0829;
      13:      prim_taps = 32'h0000_100D;
      14:      prim_taps = 32'h0000_2015;
      15:      prim_taps = 32'h0000_6000;
      16:      prim_taps = 32'h0000_D008;
      17:      prim_taps = 32'h0001_2000;
      18:      prim_taps = 32'h0002_0400;
      19:      prim_taps = 32'h0004_0023;
      20:      prim_taps = 32'h0009_0000;
      21:      prim_taps = 32'h0014_0000;
      22:      prim_taps = 32'h0030_0000;
      23:      prim_taps = 32'h0042_0000;
      24:      prim_taps = 32'h00E1_0000;
      25:      prim_taps = 32'h0120_0000;
      26:      prim_taps = 32'h0200_0023;
      27:      prim_taps = 32'h0400_0013;
      28:      prim_taps = 32'h0900_0000;
      29:      prim_taps = 32'h1400_0000;
      30:      prim_taps = 32'h2000_0029;
      31:      prim_taps = 32'h4800_0000;
      32:      prim_taps = 32'h8020_0003;
      default: prim_taps = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [32:0] max_period(input int w);
    max_period = (33'd1 << w) - 33'd1;
  endfunction

endpackage

// File: rtl/mseq_period_chk.sv
// Step counter that checks, on every return to the reference seed, whether the
// sequence length equals the maximal period 2^WIDTH-1.
module mseq_period_chk
  import mseq_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic step_i,
  input  logic wrap_i,
  input  logic clear_i,
  output logic period_ok_o,
  output logic period_err_o
);

  localparam logic [32:0] PERIOD = max_period(WIDTH);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   cnt_inc;
  logic             ok_q, err_q, hit;

  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  // A saturated count yields 2^WIDTH here, which never matches the period.
  assign hit     = (33'(cnt_inc) == PERIOD);
  assign cnt_d   = (&cnt_q) ? cnt_q : cnt_inc[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      ok_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ok_q  <= 1'b0;
      err_q <= 1'b0;
      if (clear_i) begin
        cnt_q <= '0;
      end else if (step_i) begin
        if (wrap_i) begin
          ok_q  <= hit;
          err_q <= ~hit;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  end

  assign period_ok_o  = ok_q;
  assign period_err_o = err_q;

endmodule

// File: rtl/mseq_lfsr_gen.sv
// Fibonacci LFSR M-sequence generator with seed-load handshake, zero-seed guard
// and wrap marker. Define MSEQ_PERIOD_CHECK_EN to add the runtime period checker.
module mseq_lfsr_gen
  import mseq_pkg::*;
#(
  parameter int               WIDTH        = 5,
  parameter logic [WIDTH-1:0] TAPS         = 5'b10100,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] init_state,
  input  logic             en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_seed,
  output logic             load_ready,
  output logic             m_code,
  output logic [WIDTH-1:0] state,
  output logic             frame_start,
  output logic             seed_err,
`ifdef MSEQ_PERIOD_CHECK_EN
  output logic             period_ok,
  output logic             period_err,
`endif
  output logic             dbg_fsm_state
);

  // Handshake: a load is taken in any cycle where load_valid and load_ready are
  // both high; load_ready drops for the single RELOAD cycle that follows.
  mseq_state_e      fsm_q;
  logic [WIDTH-1:0] state_q, ref_q, state_d, seed_fix, init_fix;
  logic             fb, step, accept, wrap;
  logic             m_code_q, frame_q, seed_err_q, rst_zero_q, load_ready_q;

  assign fb       = ^(state_q & TAPS);
  assign state_d  = {state_q[WIDTH-2:0], fb};
  assign accept   = (fsm_q == RUN) && load_valid;
  assign step     = (fsm_q == RUN) && !load_valid && en;
  assign wrap     = step && (state_d == ref_q);
  assign seed_fix = (load_seed == '0) ? DEFAULT_SEED : load_seed;
  assign init_fix = (init_state == '0) ? DEFAULT_SEED : init_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q        <= RUN;
      state_q      <= init_fix;
      ref_q        <= init_fix;
      m_code_q     <= 1'b0;
      frame_q      <= 1'b0;
      seed_err_q   <= 1'b0;
      rst_zero_q   <= (init_state == '0);
      load_ready_q <= 1'b1;
    end else begin
      frame_q    <= wrap;
      // A zero reset seed is reported on the first edge after release.
      seed_err_q <= rst_zero_q | (accept && (load_seed == '0));
      rst_zero_q <= 1'b0;
      case (fsm_q)
        RUN: begin
          if (accept) begin
            state_q      <= seed_fix;
            ref_q        <= seed_fix;
            fsm_q        <= RELOAD;
            load_ready_q <= 1'b0;
          end else if (step) begin
            state_q  <= state_d;
            m_code_q <= state_q[0];
          end
        end
        RELOAD: begin
          fsm_q        <= RUN;
          load_ready_q <= 1'b1;
        end
        default: begin
          fsm_q        <= RUN;
          load_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef MSEQ_PERIOD_CHECK_EN
  mseq_period_chk #(
    .WIDTH(WIDTH)
  ) u_period_chk (
    .clk         (clk),
    .reset       (reset),
    .step_i      (step),
    .wrap_i      (wrap),
    .clear_i     (accept),
    .period_ok_o (period_ok),
    .period_err_o(period_err)
  );
`endif

  assign load_ready    = load_ready_q;
  assign m_code        = m_code_q;
  assign state         = state_q;
  assign frame_start   = frame_q;
  assign seed_err      = seed_err_q;
  assign dbg_fsm_state = fsm_q;

endmodule

// File: tb/tb_mseq_lfsr_gen.sv
// Bench for mseq_lfsr_gen: scenario tasks checked against a sequence-level model;
// period pulses are checked when MSEQ_PERIOD_CHECK_EN is defined.
module tb_mseq_lfsr_gen;

  localparam int             W       = 5;
  localparam logic [W-1:0]   TAPS    = 5'b10100;
  localparam logic [W-1:0]   NP_TAPS = 5'b11000;
  localparam logic [W-1:0]   DEF     = 5'b00001;
  localparam int             FULL    = 31;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b0;
  logic [W-1:0] init_state = '0;
  logic         en = 1'b0, load_valid = 1'b0;
  logic [W-1:0] load_seed = '0;
  logic         load_ready, m_code, frame_start, seed_err, dbg_fsm;
  logic [W-1:0] state;
  logic         period_ok, period_err;

  logic         rst_np = 1'b0, en_np = 1'b0;
  logic         ready_np, code_np, frame_np, serr_np, dbg_np;
  logic [W-1:0] state_np;
  logic         pok_np, perr_np;

`ifndef MSEQ_PERIOD_CHECK_EN
  assign period_ok  = 1'b0;
  assign period_err = 1'b0;
  assign pok_np     = 1'b0;
  assign perr_np    = 1'b0;
`endif

  mseq_lfsr_gen #(.WIDTH(W), .TAPS(TAPS), .DEFAULT_SEED(DEF)) dut (
    .clk(clk), .reset(reset), .init_state(init_state), .en(en),
    .load_valid(load_valid), .load_seed(load_seed), .load_ready(load_ready),
    .m_code(m_code), .state(state), .frame_start(frame_start), .seed_err(seed_err),
`ifdef MSEQ_PERIOD_CHECK_EN
    .period_ok(period_ok), .period_err(period_err),
`endif
    .dbg_fsm_state(dbg_fsm)
  );

  mseq_lfsr_gen #(.WIDTH(W), .TAPS(NP_TAPS), .DEFAULT_SEED(DEF)) dut_np (
    .clk(clk), .reset(rst_np), .init_state(DEF), .en(en_np),
    .load_valid(1'b0), .load_seed(5'b00000), .load_ready(ready_np),
    .m_code(code_np), .state(state_np), .frame_start(frame_np), .seed_err(serr_np),
`ifdef MSEQ_PERIOD_CHECK_EN
    .period_ok(pok_np), .period_err(perr_np),
`endif
    .dbg_fsm_state(dbg_np)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  // behavioural model: sequence position, reference seed, step count since last sync
  logic [W-1:0] m_state, m_ref;
  logic         m_code_e, m_frame, m_serr, m_ready, m_pend, m_pok, m_perr;
  int           m_cnt;

  function automatic logic [W-1:0] next_of(input logic [W-1:0] s, input logic [W-1:0] t);
    int par;
    par = $countones(s & t) % 2;
    return {s[W-2:0], par[0]};
  endfunction

  task automatic model_reset(input logic [W-1:0] init);
    m_state = (init == 0) ? DEF : init;
    m_ref = m_state; m_code_e = 0; m_frame = 0; m_serr = 0;
    m_ready = 1; m_pend = (init == 0); m_cnt = 0; m_pok = 0; m_perr = 0;
  endtask

  // driver tasks
  task automatic apply_reset(input logic [W-1:0] init);
    en = 0; load_valid = 0; load_seed = '0; init_state = init;
    reset = 1'b1;
    model_reset(init);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drive_cycle(input logic v_en, input logic v_lv, input logic [W-1:0] v_seed);
    logic [W-1:0] nxt;
    en = v_en; load_valid = v_lv; load_seed = v_seed;
    @(posedge clk); #1;
    m_frame = 0; m_pok = 0; m_perr = 0; m_serr = m_pend; m_pend = 0;
    if (!m_ready) begin
      m_ready = 1;
    end else if (v_lv) begin
      m_state = (v_seed == 0) ? DEF : v_seed;
      m_ref = m_state; m_ready = 0; m_cnt = 0;
      if (v_seed == 0) m_serr = 1;
    end else if (v_en) begin
      nxt = next_of(m_state, TAPS);
      m_code_e = m_state[0];
      m_cnt++;
      if (nxt == m_ref) begin
        m_frame = 1;
`ifdef MSEQ_PERIOD_CHECK_EN
        m_pok = (m_cnt == FULL); m_perr = (m_cnt != FULL);
`endif
        m_cnt = 0;
      end
      m_state = nxt;
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] r;
    r = W'($urandom_range(1, 31));
    init_state = r; en = 1; load_valid = 0;
    reset = 1'b0; rst_np = 1'b0;
    #1; reset = 1'b1; rst_np = 1'b1;
    model_reset(r);
    #1;
    n_checks++; if (state !== r) begin n_fail++; $display("FAIL reset_state: got %0h exp %0h", state, r); end
    n_checks++; if (m_code !== 1'b0) begin n_fail++; $display("FAIL reset_m_code: got %0b exp 0", m_code); end
    n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b exp 1", load_ready); end
    n_checks++; if (dbg_fsm !== 1'b0) begin n_fail++; $display("FAIL reset_fsm: got %0b exp 0", dbg_fsm); end
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if ({frame_start, seed_err, period_ok, period_err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b exp 0000", {frame_start, seed_err, period_ok, period_err}); end
    n_checks++; if (state !== r) begin n_fail++; $display("FAIL reset_hold_en: got %0h exp %0h", state, r); end
    rst_np = 1'b0;
    apply_reset(r);
    drive_cycle(0, 0, '0);
    n_checks++; if (state !== r || m_code !== 1'b0) begin
      n_fail++; $display("FAIL en_low_hold: got %0h/%0b exp %0h/0", state, m_code, r); end
  endtask

  task automatic test_basic();
    logic [W-1:0] exp_s[3];
    logic         exp_c[3];
    exp_s = '{5'b00010, 5'b00100, 5'b01001};
    exp_c = '{1'b1, 1'b0, 1'b0};
    apply_reset(5'b00001);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 0, '0);
      n_checks++; if (state !== exp_s[i]) begin n_fail++; $display("FAIL basic_state%0d: got %b exp %b", i, state, exp_s[i]); end
      n_checks++; if (m_code !== exp_c[i]) begin n_fail++; $display("FAIL basic_code%0d: got %b exp %b", i, m_code, exp_c[i]); end
    end
  endtask

  task automatic test_full_period();
    int frames, oks;
    frames = 0; oks = 0;
    exp_q.delete();
    apply_reset(5'b00001);
    for (int i = 1; i <= 2 * FULL; i++) begin
      drive_cycle(1, 0, '0);
      if (i <= FULL) begin
        exp_q.push_back(m_code);
        frames += frame_start; oks += period_ok;
      end else begin
        n_checks++; if (m_code !== exp_q[0]) begin n_fail++; $display("FAIL repeat_code%0d: got %b exp %b", i, m_code, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      n_checks++; if (state !== m_state || frame_start !== m_frame) begin
        n_fail++; $display("FAIL period_step%0d: got %0h/%b exp %0h/%b", i, state, frame_start, m_state, m_frame); end
      if (i == FULL) begin
        n_checks++; if (frame_start !== 1'b1 || state !== 5'b00001) begin
          n_fail++; $display("FAIL wrap31: got %b/%0h exp 1/1", frame_start, state); end
`ifdef MSEQ_PERIOD_CHECK_EN
        n_checks++; if (period_ok !== 1'b1 || period_err !== 1'b0) begin
          n_fail++; $display("FAIL period_ok31: got %b%b exp 10", period_ok, period_err); end
`endif
      end
    end
    n_checks++; if (frames !== 1) begin n_fail++; $display("FAIL frame_count: got %0d exp 1", frames); end
`ifdef MSEQ_PERIOD_CHECK_EN
    n_checks++; if (oks !== 1) begin n_fail++; $display("FAIL ok_count: got %0d exp 1", oks); end
`endif
  endtask

  task automatic test_zero_seed();
    apply_reset('0);
    drive_cycle(0, 0, '0);
    n_checks++; if (state !== DEF || seed_err !== 1'b1) begin
      n_fail++; $display("FAIL zero_reset: got %0h/%b exp 1/1", state, seed_err); end
    drive_cycle(1, 0, '0);
    n_checks++; if (seed_err !== 1'b0) begin n_fail++; $display("FAIL zero_reset_pulse: got %b exp 0", seed_err); end
    drive_cycle(1, 0, '0);
    drive_cycle(0, 1, '0);
    n_checks++; if (state !== DEF || seed_err !== 1'b1 || load_ready !== 1'b0) begin
      n_fail++; $display("FAIL zero_load: got %0h/%b/%b exp 1/1/0", state, seed_err, load_ready); end
    drive_cycle(0, 0, '0);
    n_checks++; if (seed_err !== 1'b0 || load_ready !== 1'b1) begin
      n_fail++; $display("FAIL zero_load_after: got %b/%b exp 0/1", seed_err, load_ready); end
  endtask

  task automatic test_collision();
    logic held;
    apply_reset(W'($urandom_range(1, 31)));
    for (int i = 0; i < 4; i++) drive_cycle(1, 0, '0);
    held = m_code_e;
    drive_cycle(1, 1, 5'b10101);
    n_checks++; if (state !== 5'b10101 || m_code !== held || load_ready !== 1'b0 || dbg_fsm !== 1'b1) begin
      n_fail++; $display("FAIL collide_load: got %0h/%b/%b/%b exp 15/%b/0/1", state, m_code, load_ready, dbg_fsm, held); end
    drive_cycle(1, 1, 5'b00111);
    n_checks++; if (state !== 5'b10101 || load_ready !== 1'b1) begin
      n_fail++; $display("FAIL reload_no_step: got %0h/%b exp 15/1", state, load_ready); end
    drive_cycle(1, 0, '0);
    n_checks++; if (state !== next_of(5'b10101, TAPS) || m_code !== 1'b1) begin
      n_fail++; $display("FAIL resume_step: got %0h/%b exp %0h/1", state, m_code, next_of(5'b10101, TAPS)); end
  endtask

  task automatic test_random();
    logic lv;
    apply_reset(W'($urandom_range(0, 31)));
    for (int i = 0; i < 400; i++) begin
      lv = ($urandom_range(0, 9) == 0);
      drive_cycle(($urandom_range(0, 3) != 0), lv, W'($urandom_range(0, 31)));
      n_checks++;
      if (state !== m_state || m_code !== m_code_e || frame_start !== m_frame || seed_err !== m_serr ||
          load_ready !== m_ready || period_ok !== m_pok || period_err !== m_perr) begin
        n_fail++;
        $display("FAIL random%0d: got %0h %b%b%b%b%b%b exp %0h %b%b%b%b%b%b", i, state, m_code, frame_start,
                 seed_err, load_ready, period_ok, period_err, m_state, m_code_e, m_frame, m_serr, m_ready, m_pok, m_perr);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] r;
    r = W'($urandom_range(1, 31));
    apply_reset(r);
    for (int i = 0; i < 16; i++) drive_cycle(1, 0, '0);
    n_checks++; if (state !== m_state) begin n_fail++; $display("FAIL pre_reset16: got %0h exp %0h", state, m_state); end
    en = 1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (state !== r || m_code !== 1'b0 || load_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: got %0h/%b/%b exp %0h/0/1", state, m_code, load_ready, r); end
    apply_reset(r);
    for (int i = 1; i <= FULL; i++) begin
      drive_cycle(1, 0, '0);
      n_checks++; if (frame_start !== (i == FULL) || period_ok !== m_pok || period_err !== m_perr) begin
        n_fail++; $display("FAIL after_reset%0d: got %b%b%b exp %b%b%b", i, frame_start, period_ok, period_err,
                           (i == FULL), m_pok, m_perr); end
    end
  endtask

  task automatic test_non_primitive();
    logic [W-1:0] s;
    int n;
    s = DEF; n = 0;
    do begin s = next_of(s, NP_TAPS); n++; end while (s != DEF && n < 64);
    rst_np = 1'b1;
    @(posedge clk); #1; rst_np = 1'b0; en_np = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      n_checks++; if (frame_np !== (i == n)) begin n_fail++; $display("FAIL np_frame%0d: got %b exp %b", i, frame_np, (i == n)); end
`ifdef MSEQ_PERIOD_CHECK_EN
      n_checks++; if (pok_np !== 1'b0 || perr_np !== (i == n)) begin
        n_fail++; $display("FAIL np_period%0d: got %b%b exp 0%b", i, pok_np, perr_np, (i == n)); end
`endif
    end
    en_np = 1'b0;
    n_checks++; if (n >= 31) begin n_fail++; $display("FAIL np_short_cycle: got %0d exp <31", n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_period();
    test_zero_seed();
    test_collision();
    test_random();
    test_mid_reset();
    test_non_primitive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
